cla_addsub_pipe: RTL and testbench
==================================

Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined two-level carry-lookahead adder/subtractor; successor of the fixed 16-bit combinational CLA.
- WIDTH-bit operands, add/sub mode, carry-in, status flags.
- Three register stages with a valid/ready handshake at each end and per-stage bubble collapse.
- Sits between an operand-producing datapath and a result consumer that may stall.

Parameters:
- WIDTH, 16, operand/result width; multiple of 4, range 8..64; other values are a compile-time error.
- NG, WIDTH/4, number of 4-bit groups; derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts the beat this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_op  in  1  op_t: 0 = ADD, 1 = SUB
- in_cin  in  1  carry-in; ignored for SUB, which forces cin = 1
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry-out; for SUB, 1 = no borrow
- out_ovf  out  1  signed overflow
- out_zero  out  1  out_sum == 0

Behaviour:
- Transfer occurs on a clock edge where valid && ready.
- Stage registers: S1, S2, S3, each with a valid bit v1..v3.
- Stage k loads when !vk || (stage k+1 loads or drains). S3 drains on out_ready.
- in_ready = !v1 || S1 advances. This is combinational from out_ready through the valid bits only, never from data.
- Latency: exactly 3 cycles from input transfer to out_valid with no stall. Full throughput is 1 result per cycle.
- S1 captures per bit p = a ^ b' and g = a & b', where b' = op ? ~b : b. It also captures cin' = op ? 1 : in_cin, op, and the sign bits of a and b'.
- S2 captures:
  - group P/G for each of the NG groups (cla_group4);
  - group carries from second-level lookahead over 4-group superblocks, with carry rippling between superblocks;
  - the per-bit p vector.
- S3 captures:
  - sum = p ^ c (c from in-group lookahead on the group carry);
  - cout = carry out of MSB;
  - ovf = carry into MSB ^ carry out of MSB;
  - zero = (sum == 0), evaluated after the optional saturation.
- Outputs are driven directly from S3 registers; there is no combinational path from inputs to outputs.
- A stalled S3 holds out_sum and flags stable while out_valid && !out_ready.
- Bubbles collapse: an empty stage fills even while S3 is stalled. With S3 stalled and the pipe full, in_ready = 0.
- Wrap-around is modulo 2^WIDTH: 0xFFFF + 1 → 0x0000, cout = 1.
- Reset (async, any cycle including mid-operation):
  - v1..v3 = 0, out_valid = 0, in_ready = 1 once rst is deasserted;
  - out_sum = 0, out_cout = 0, out_ovf = 0, out_zero = 0;
  - in-flight beats are discarded.
- Data registers need no reset except S3. Valid bits must be reset.

Optional Feature:
- Macro: CLA_ADDSUB_SAT_EN.
- Defined: on ovf, out_sum saturates to the signed limit of the operand direction. Positive overflow gives 0x7F..F; negative overflow gives 0x80..0. out_ovf still reports 1. out_cout is unmodified. Saturation logic sits in S3 and adds no latency.
- Undefined: out_sum is the wrapped result.

Decomposition:
- Package cla_pkg:
  - typedef enum logic {OP_ADD, OP_SUB} op_t;
  - localparam GRP_W = 4;
  - typedef struct for the S1 payload (p, g, cin, op, sign bits).
- Sub-module cla_group4: combinational. Inputs p[3:0], g[3:0], cin. Outputs P, G, c[3:0]. Instantiated NG times in S2/S3.

Test Plan (WIDTH=16, out_ready=1 unless noted):
- ADD 0x1234 + 0x4321, cin 0 → after 3 cycles out_sum 0x5555, cout 0, ovf 0, zero 0.
- ADD 0xFFFF + 0x0001, cin 0 → out_sum 0x0000, cout 1, zero 1, ovf 0. ADD 0x00FF + 0x0000, cin 1 → 0x0100.
- SUB 0x8000 − 0x0001 → ovf 1, cout 1; out_sum 0x7FFF, or 0x8000 with CLA_ADDSUB_SAT_EN.
- ADD 0x7FFF + 0x0001 → ovf 1; out_sum 0x8000, or 0x7FFF with CLA_ADDSUB_SAT_EN.
- Stall: 5 back-to-back beats, out_ready = 0 on cycles 3..7.
  - in_ready falls exactly when S1..S3 are all full;
  - no beat is lost or duplicated and order is preserved;
  - out_sum is stable while stalled.
- Reset mid-operation: rst pulsed with 2 beats in flight → out_valid = 0 and outputs zero immediately. After release, only post-reset beats appear, 3 cycles after acceptance.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder/subtractor.
//
// Contents:
//   op_t           operation select (OP_ADD / OP_SUB)
//   GRP_W          lookahead group width (bits per group)
//   MAX_W          widest operand supported; the S1 payload is sized for it
//   s1_t           stage-1 payload: per-bit propagate/generate, effective
//                  carry-in, operation and the operand sign bits
//   cla4_carries   carry vector of one 4-wide lookahead block, used for the
//                  second (group-of-groups) lookahead level

package cla_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    localparam int GRP_W = 4;
    localparam int MAX_W = 64;

    typedef struct packed {
        logic [MAX_W-1:0] p;
        logic [MAX_W-1:0] g;
        logic             cin;
        op_t              op;
        logic             sign_a;
        logic             sign_b;
    } s1_t;

    // Returns {carry out, carries into positions 3..0}; bit 0 is cin itself.
    function automatic logic [GRP_W:0] cla4_carries(
        input logic [GRP_W-1:0] p,
        input logic [GRP_W-1:0] g,
        input logic             cin
    );
        logic [GRP_W:0] c;
        c[0] = cin;
        for (int i = 0; i < GRP_W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group.
//
// Ports:
//   p[3:0], g[3:0]  per-bit propagate / generate
//   cin             carry into bit 0 of the group
//   grp_p, grp_g    group propagate / generate
//   c[3:0]          carry into each bit of the group (c[0] = cin)

module cla_group4
    import cla_pkg::*;
(
    input  logic [GRP_W-1:0] p,
    input  logic [GRP_W-1:0] g,
    input  logic             cin,
    output logic             grp_p,
    output logic             grp_g,
    output logic [GRP_W-1:0] c
);

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign grp_p = &p;
    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_addsub_pipe.sv
// Three-stage pipelined two-level carry-lookahead adder/subtractor with
// valid/ready handshakes on both sides and per-stage bubble collapse.
//
//   S1: operand conditioning -> per-bit p/g, effective carry-in, sign bits
//   S2: group P/G (cla_group4) and group carries from a second lookahead
//       level over 4-group superblocks, rippling between superblocks
//   S3: in-group carries, sum, carry-out, overflow, zero (outputs registered)
//
// Build option: define CLA_ADDSUB_SAT_EN to saturate out_sum to the signed
// limit on overflow (0x7F..F for positive, 0x80..0 for negative overflow).
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake
//   in_a, in_b            operands (WIDTH bits)
//   in_op                 OP_ADD / OP_SUB
//   in_cin                carry-in (ignored for OP_SUB, which uses 1)
//   out_valid / out_ready result handshake
//   out_sum               result (WIDTH bits)
//   out_cout              carry-out (for SUB, 1 = no borrow)
//   out_ovf               signed overflow
//   out_zero              out_sum == 0

module cla_addsub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  op_t              in_op,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NG  = WIDTH / GRP_W;
    localparam int NSB = (NG + 3) / 4;

    if ((WIDTH % GRP_W) != 0 || WIDTH < 8 || WIDTH > MAX_W) begin : g_width_check
        $error("cla_addsub_pipe: WIDTH must be a multiple of 4 in 8..64");
    end

    // ------------------------------------------------------------------
    // Handshake: a stage may load when it is empty or its content moves on.
    // Depends only on valid bits and out_ready.
    // ------------------------------------------------------------------
    logic v1, v2, v3;
    logic en1, en2, en3;
    logic ld1, ld2, ld3;

    assign en3 = !v3 || out_ready;
    assign en2 = !v2 || en3;
    assign en1 = !v1 || en2;
    assign ld1 = en1 && in_valid;
    assign ld2 = en2 && v1;
    assign ld3 = en3 && v2;

    assign in_ready  = en1;
    assign out_valid = v3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (en1) v1 <= in_valid;
            if (en2) v2 <= v1;
        end
    end

    // ------------------------------------------------------------------
    // S1
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] b_eff;
    s1_t              s1_d;
    s1_t              s1_q;

    assign b_eff = (in_op == OP_SUB) ? ~in_b : in_b;

    always_comb begin
        s1_d                = '0;
        s1_d.p[WIDTH-1:0]   = in_a ^ b_eff;
        s1_d.g[WIDTH-1:0]   = in_a & b_eff;
        s1_d.cin            = (in_op == OP_SUB) ? 1'b1 : in_cin;
        s1_d.op             = in_op;
        s1_d.sign_a         = in_a[WIDTH-1];
        s1_d.sign_b         = b_eff[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (ld1) s1_q <= s1_d;
    end

    // ------------------------------------------------------------------
    // S2: group P/G, then carries into every group
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]     p1, g1;
    logic [NG-1:0]        gp, gg;
    logic [WIDTH-1:0]     s2_unused_c;
    logic [NSB*4-1:0]     gp_pad, gg_pad, gc_pad;
    logic [GRP_W:0]       sb_c;
    logic                 sb_carry;

    assign p1 = s1_q.p[WIDTH-1:0];
    assign g1 = s1_q.g[WIDTH-1:0];

    for (genvar i = 0; i < NG; i++) begin : g_s2_grp
        cla_group4 u_grp (
            .p     (p1[GRP_W*i +: GRP_W]),
            .g     (g1[GRP_W*i +: GRP_W]),
            .cin   (1'b0),
            .grp_p (gp[i]),
            .grp_g (gg[i]),
            .c     (s2_unused_c[GRP_W*i +: GRP_W])
        );
    end

    // Unused pad groups have P = G = 0 so they never affect real carries.
    always_comb begin
        gp_pad         = '0;
        gg_pad         = '0;
        gc_pad         = '0;
        sb_c           = '0;
        gp_pad[NG-1:0] = gp;
        gg_pad[NG-1:0] = gg;
        sb_carry       = s1_q.cin;
        for (int j = 0; j < NSB; j++) begin
            sb_c              = cla4_carries(gp_pad[4*j +: 4], gg_pad[4*j +: 4], sb_carry);
            gc_pad[4*j +: 4]  = sb_c[3:0];
            sb_carry          = sb_c[4];
        end
    end

    logic [WIDTH-1:0] s2_p, s2_g;
    logic [NG-1:0]    s2_gp, s2_gg, s2_gc;
    logic             s2_neg;

    always_ff @(posedge clk) begin
        if (ld2) begin
            s2_p   <= p1;
            s2_g   <= g1;
            s2_gp  <= gp;
            s2_gg  <= gg;
            s2_gc  <= gc_pad[NG-1:0];
            // Overflow can only be negative when both operands are negative.
            s2_neg <= s1_q.sign_a & s1_q.sign_b;
        end
    end

    // ------------------------------------------------------------------
    // S3: in-group carries, sum and flags
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] c_vec;
    logic [NG-1:0]    s3_unused_p, s3_unused_g;
    logic [WIDTH-1:0] sum_raw, sum_fin;
    logic             cout, ovf;

    for (genvar i = 0; i < NG; i++) begin : g_s3_grp
        cla_group4 u_grp (
            .p     (s2_p[GRP_W*i +: GRP_W]),
            .g     (s2_g[GRP_W*i +: GRP_W]),
            .cin   (s2_gc[i]),
            .grp_p (s3_unused_p[i]),
            .grp_g (s3_unused_g[i]),
            .c     (c_vec[GRP_W*i +: GRP_W])
        );
    end

    assign sum_raw = s2_p ^ c_vec;
    assign cout    = s2_gg[NG-1] | (s2_gp[NG-1] & s2_gc[NG-1]);
    assign ovf     = c_vec[WIDTH-1] ^ cout;

    logic unused_bits;

`ifdef CLA_ADDSUB_SAT_EN
    always_comb begin
        sum_fin = sum_raw;
        if (ovf) begin
            sum_fin = s2_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
    assign unused_bits = ^{s1_q, gc_pad, s2_gp, s2_gg, sb_carry};
`else
    assign sum_fin     = sum_raw;
    assign unused_bits = ^{s1_q, gc_pad, s2_gp, s2_gg, sb_carry, s2_neg};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3       <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
        end else begin
            if (en3) v3 <= v2;
            if (ld3) begin
                out_sum  <= sum_fin;
                out_cout <= cout;
                out_ovf  <= ovf;
                out_zero <= (sum_fin == '0);
            end
        end
    end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
module tb_cla_addsub_pipe;
    import cla_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    op_t          in_op;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout, out_ovf, out_zero;

    cla_addsub_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    int           n_vec = 0;
    int           n_err = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_sum = '0;

    // Plain-arithmetic reference: unsigned sum for carry, signed sum for overflow.
    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic op, logic cin, int acc);
        exp_t   e;
        longint lim  = longint'(1) << W;
        longint half = longint'(1) << (W - 1);
        longint ua   = longint'(a);
        longint ub   = longint'(b);
        longint sa   = longint'($signed(a));
        longint sbv  = longint'($signed(b));
        longint full, sres;
        if (op) begin
            full = ua + (lim - 1 - ub) + 1;
            sres = sa - sbv;
        end else begin
            full = ua + ub + longint'(cin);
            sres = sa + sbv + longint'(cin);
        end
        e.sum  = W'(full);
        e.cout = (full >= lim);
        e.ovf  = (sres > half - 1) || (sres < -half);
`ifdef CLA_ADDSUB_SAT_EN
        if (e.ovf) e.sum = (sres > 0) ? W'(half - 1) : W'(half);
`endif
        e.zero = (e.sum == 0);
        e.acc  = acc;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input logic cin);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op_t'(op);
        in_cin   = cin;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // One clock: sample at the falling edge, update the model, return just after
    // the next rising edge so the caller can drive new inputs.
    task automatic step(output logic accepted);
        logic exp_ov;
        exp_t h;
        @(negedge clk);
        exp_ov = (sb.size() > 0) && (cyc - sb[0].acc >= 3);
        chk("out_valid", out_valid, exp_ov);
        chk("in_ready", in_ready, (sb.size() < 3) || out_ready);
        if (exp_ov && out_valid) begin
            h = sb[0];
            chk("out_sum", out_sum, h.sum);
            chk("out_cout", out_cout, h.cout);
            chk("out_ovf", out_ovf, h.ovf);
            chk("out_zero", out_zero, h.zero);
        end
        if (prev_stall && out_valid) chk("stall_stable", out_sum, prev_sum);
        prev_stall = out_valid && !out_ready;
        prev_sum   = out_sum;
        if (exp_ov && out_ready) void'(sb.pop_front());
        accepted = in_valid && in_ready;
        if (accepted) begin
            sb.push_back(model(in_a, in_b, in_op, in_cin, cyc));
            n_vec++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_sum"}, out_sum, '0);
        chk({tag, "_out_cout"}, out_cout, 1'b0);
        chk({tag, "_out_ovf"}, out_ovf, 1'b0);
        chk({tag, "_out_zero"}, out_zero, 1'b0);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    logic [W-1:0] da [6] = '{16'h1234, 16'hFFFF, 16'h00FF, 16'h8000, 16'h7FFF, 16'h0000};
    logic [W-1:0] db [6] = '{16'h4321, 16'h0001, 16'h0000, 16'h0001, 16'h0001, 16'h0000};
    logic         dop[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic         dci[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [W-1:0] corner[4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};

    initial begin
        logic         acc;
        int           k;
        logic [W-1:0] ra, rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = OP_ADD;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors, back to back, consumer always ready
        for (int i = 0; i < 6; i++) begin
            drive(da[i], db[i], dop[i], dci[i]);
            step(acc);
        end
        idle();
        for (int i = 0; i < 5; i++) step(acc);

        // SUB ignores cin; isolated beat checks the bare latency
        drive(16'h0005, 16'h0007, 1'b1, 1'b1);
        step(acc);
        idle();
        for (int i = 0; i < 5; i++) step(acc);

        // Stall: five back-to-back beats, consumer stalls on cycles 3..7
        k = 0;
        for (int i = 0; i < 16; i++) begin
            out_ready = !(i >= 3 && i <= 7);
            if (k < 5) drive(16'h1000 * W'(k + 1), 16'h0111 * W'(k + 1), 1'b0, 1'b0);
            else idle();
            step(acc);
            if (acc) k++;
        end
        out_ready = 1'b1;

        // Randomised traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            if ($urandom_range(0, 9) < 8) drive(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else idle();
            out_ready = ($urandom_range(0, 9) < 7);
            step(acc);
        end
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step(acc);

        // Reset with the pipe full: S3 holds 0x8000+0x8000 (all flags set)
        drive(16'h8000, 16'h8000, 1'b0, 1'b0);
        step(acc);
        drive(16'h0101, 16'h0202, 1'b0, 1'b0);
        step(acc);
        drive(16'h0303, 16'h0404, 1'b0, 1'b0);
        step(acc);
        idle();
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        sb.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("post_reset");

        drive(16'h2222, 16'h1111, 1'b1, 1'b0);
        step(acc);
        drive(16'h0F0F, 16'h00F1, 1'b0, 1'b1);
        step(acc);
        idle();
        for (int i = 0; i < 6; i++) step(acc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
